// File: rtl/counter_drain_pkg.sv
// Shared types and constants for the counter block drain engine.
package counter_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Expected value of the two header bytes at the front of every block.
  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hAA;

  // Byte index counters are 6 bits wide and never wrap inside a block.
  localparam int CNT_W = 6;

  // Byte positions of the header and counter fields (big-endian fields).
  localparam int HDR_IDX_LO = 0;
  localparam int HDR_IDX_HI = 1;
  localparam int PPS_IDX_LO = 2;
  localparam int PPS_IDX_HI = 3;
  localparam int TEN_IDX_LO = 4;
  localparam int TEN_IDX_HI = 7;
  localparam int EVT_IDX_LO = 8;
  localparam int EVT_IDX_HI = 11;

  // True when a byte index falls inside the inclusive range [lo, hi].
  function automatic logic idx_in(input logic [CNT_W-1:0] idx, input int lo, input int hi);
    return (int'(idx) >= lo) && (int'(idx) <= hi);
  endfunction

endpackage

// File: rtl/counter_drain_if.sv
// Counter FIFO read port plus the outgoing byte stream of the drain engine.
interface counter_drain_if;
  logic       cfifo_rden;
  logic [7:0] cfifo_dout;
  logic       cfifo_empty;
  logic       cfifo_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  // master: the drain engine; slave: the FIFO and the downstream byte sink.
  modport master (
    output cfifo_rden,
    input  cfifo_dout, cfifo_empty, cfifo_valid,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  cfifo_rden,
    output cfifo_dout, cfifo_empty, cfifo_valid,
    input  out_data, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/counter_drain_skid.sv
// Two-entry byte FIFO decoupling FIFO read latency from output backpressure.
module byte_skid_buf (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] count
);

  logic [7:0] mem_q [2];
  logic [7:0] mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Next-state: write at wr_ptr on push, advance rd_ptr on pop, track occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the buffer and zeroes the output byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/counter_drain.sv
// Drains one fixed-size counter block from a FIFO into a byte stream,
// checking the header and latching the PPS / 10 MHz / event counter fields.
module counter_drain
  import counter_drain_pkg::*;
#(
  parameter int         BLOCK_BYTES = 32,
  parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEFAULT,
  parameter int         TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  counter_drain_if.master bus,
  output logic        busy,
  output logic        done,
  output logic        hdr_err,
  output logic        tmo_err,
  output logic [15:0] pps_num,
  output logic [31:0] tenmhz_num,
  output logic [31:0] evt_num
);

  localparam int             TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] BLK_CNT  = CNT_W'(BLOCK_BYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               inflight_q, inflight_d;
  logic               hdr_err_q, hdr_err_d;
  logic               tmo_err_q, tmo_err_d;
  logic [15:0]        pps_sh_q, pps_sh_d, pps_q, pps_d;
  logic [31:0]        ten_sh_q, ten_sh_d, ten_q, ten_d;
  logic [31:0]        evt_sh_q, evt_sh_d, evt_q, evt_d;

  logic       take_byte, pop_now, tmo_hit, room, rden;
  logic       skid_in_ready, skid_out_valid;
  logic [7:0] skid_out_data;
  logic [1:0] skid_count;
  logic [2:0] occ_net;

  // Valid bytes are only accepted while a block is active; IDLE/DONE drop them.
  assign take_byte = bus.cfifo_valid && ((state_q == ST_READ) || (state_q == ST_FLUSH));
  assign pop_now   = skid_out_valid && bus.out_ready;
  assign tmo_hit   = (state_q == ST_READ) && !take_byte && (tmo_cnt_q == TMO_LAST);
  // Count the slot freed by this cycle's output transfer so a full-rate stream never stalls.
  assign occ_net   = {1'b0, skid_count} - {2'b00, pop_now} + {2'b00, inflight_q};
  assign room      = (occ_net < 3'd2);
  assign rden      = (state_q == ST_READ) && !bus.cfifo_empty && (req_cnt_q < BLK_CNT)
                     && room && skid_in_ready && !tmo_hit;

  byte_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (bus.cfifo_dout),
    .in_valid  (take_byte),
    .in_ready  (skid_in_ready),
    .out_data  (skid_out_data),
    .out_valid (skid_out_valid),
    .out_ready (bus.out_ready),
    .count     (skid_count)
  );

  assign bus.cfifo_rden = rden;
  assign bus.out_data   = skid_out_data;
  assign bus.out_valid  = skid_out_valid;
  assign bus.out_last   = skid_out_valid && (out_cnt_q == LAST_IDX);

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign hdr_err    = hdr_err_q;
  assign tmo_err    = tmo_err_q;
  assign pps_num    = pps_q;
  assign tenmhz_num = ten_q;
  assign evt_num    = evt_q;

  // Next-state logic: block FSM, byte/request counters, header check and field capture.
  always_comb begin
    state_d    = state_q;
    req_cnt_d  = req_cnt_q + CNT_W'(rden);
    byte_cnt_d = byte_cnt_q;
    out_cnt_d  = out_cnt_q + CNT_W'(pop_now);
    tmo_cnt_d  = tmo_cnt_q;
    inflight_d = rden;
    hdr_err_d  = hdr_err_q;
    tmo_err_d  = tmo_err_q;
    pps_sh_d   = pps_sh_q;
    ten_sh_d   = ten_sh_q;
    evt_sh_d   = evt_sh_q;
    pps_d      = pps_q;
    ten_d      = ten_q;
    evt_d      = evt_q;

    if (take_byte) begin
      byte_cnt_d = byte_cnt_q + 1'b1;
      if (idx_in(byte_cnt_q, HDR_IDX_LO, HDR_IDX_HI) && (bus.cfifo_dout != HDR_BYTE))
        hdr_err_d = 1'b1;
      if (idx_in(byte_cnt_q, PPS_IDX_LO, PPS_IDX_HI)) pps_sh_d = {pps_sh_q[7:0], bus.cfifo_dout};
      if (idx_in(byte_cnt_q, TEN_IDX_LO, TEN_IDX_HI)) ten_sh_d = {ten_sh_q[23:0], bus.cfifo_dout};
      if (idx_in(byte_cnt_q, EVT_IDX_LO, EVT_IDX_HI)) evt_sh_d = {evt_sh_q[23:0], bus.cfifo_dout};
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_READ;
          req_cnt_d  = '0;
          byte_cnt_d = '0;
          out_cnt_d  = '0;
          tmo_cnt_d  = '0;
          hdr_err_d  = 1'b0;
          tmo_err_d  = 1'b0;
        end
      end
      ST_READ: begin
        if (take_byte) begin
          tmo_cnt_d = '0;
          if (byte_cnt_q == LAST_IDX) state_d = ST_FLUSH;
        end else if (tmo_hit) begin
          tmo_err_d = 1'b1;
          state_d   = ST_FLUSH;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        if ((skid_count == 2'd0) && !inflight_q) begin
          state_d = ST_DONE;
          // Publish the fields together with the DONE pulse, unless the block timed out.
          if (!tmo_err_q) begin
            pps_d = pps_sh_q;
            ten_d = ten_sh_q;
            evt_d = evt_sh_q;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      req_cnt_q  <= '0;
      byte_cnt_q <= '0;
      out_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      inflight_q <= 1'b0;
      hdr_err_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
      pps_sh_q   <= '0;
      ten_sh_q   <= '0;
      evt_sh_q   <= '0;
      pps_q      <= '0;
      ten_q      <= '0;
      evt_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_cnt_q  <= req_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      out_cnt_q  <= out_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      inflight_q <= inflight_d;
      hdr_err_q  <= hdr_err_d;
      tmo_err_q  <= tmo_err_d;
      pps_sh_q   <= pps_sh_d;
      ten_sh_q   <= ten_sh_d;
      evt_sh_q   <= evt_sh_d;
      pps_q      <= pps_d;
      ten_q      <= ten_d;
      evt_q      <= evt_d;
    end
  end

endmodule
